// File: rtl/blink_pattern_player.sv
// blink_pattern_player
// Plays a loadable on/off LED pattern MSB first, holding each bit for TICK_DIV
// clock cycles, with a LOAD/BUSY/DONE handshake and optional looping.
// USBPU is tied low so the USB pull-up stays disabled, as on the other LED tops.

module blink_pattern_player #(
   parameter int PATTERN_LEN = 32,
   parameter int TICK_DIV    = 1_600_000
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [PATTERN_LEN-1:0] PATTERN,
   input  logic                   LOAD,
   input  logic                   LOOP,
   output logic                   LED,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   USBPU
);

   // Prescaler needs at least one bit even when every bit lasts a single cycle.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = $clog2(PATTERN_LEN);

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [IW-1:0] INDEX_MAX = IW'(PATTERN_LEN - 1);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [PATTERN_LEN-1:0] shadow_q, shadow_d;
   logic [PW-1:0]          presc_q, presc_d;
   logic [IW-1:0]          index_q, index_d;
   logic                   led_q, led_d;
   logic                   done_q, done_d;

   // State and datapath registers; reset returns everything to idle with the LED dark.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         presc_q  <= '0;
         index_q  <= '0;
         led_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         presc_q  <= presc_d;
         index_q  <= index_d;
         led_q    <= led_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic: load in IDLE, step through the shadow copy once per tick in PLAY.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      presc_d  = presc_q;
      index_d  = index_q;
      led_d    = led_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            led_d = 1'b0;
            if (LOAD) begin
               shadow_d = PATTERN;
               index_d  = '0;
               presc_d  = '0;
               led_d    = PATTERN[PATTERN_LEN-1];
               state_d  = PLAY;
            end
         end

         PLAY: begin
            if (presc_q == PRESC_MAX) begin
               presc_d = '0;
               if (index_q == INDEX_MAX) begin
                  if (LOOP) begin
                     index_d = '0;
                     led_d   = shadow_q[PATTERN_LEN-1];
                  end else begin
                     state_d = IDLE;
                     led_d   = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  index_d = index_q + IW'(1);
                  led_d   = shadow_q[INDEX_MAX - index_d];
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            led_d   = 1'b0;
         end
      endcase
   end

   assign LED   = led_q;
   assign BUSY  = (state_q == PLAY);
   assign DONE  = done_q;
   assign USBPU = 1'b0;

endmodule

// File: tb/tb_blink_pattern_player.sv
// tb_blink_pattern_player
// Scoreboard bench: each scenario pushes the expected per-cycle {LED,BUSY,DONE}
// when it starts a pattern and pops one entry per clock as the DUT plays it.

module tb_blink_pattern_player;

   logic       TEST_CLK;
   logic       RST_N;
   logic [7:0] PATTERN;
   logic       LOAD;
   logic       LOOP;
   logic       LED, BUSY, DONE, USBPU;
   logic       LOAD1;
   logic       LED1, BUSY1, DONE1, USBPU1;

   logic [2:0] sb_q[$];
   logic [2:0] exp_v;
   logic [2:0] obs_v;
   int         n_compared;
   int         n_failed;

   blink_pattern_player #(.PATTERN_LEN(8), .TICK_DIV(4)) dut (
      .CLK(TEST_CLK), .RST_N(RST_N), .PATTERN(PATTERN), .LOAD(LOAD), .LOOP(LOOP),
      .LED(LED), .BUSY(BUSY), .DONE(DONE), .USBPU(USBPU)
   );

   blink_pattern_player #(.PATTERN_LEN(8), .TICK_DIV(1)) dut1 (
      .CLK(TEST_CLK), .RST_N(RST_N), .PATTERN(PATTERN), .LOAD(LOAD1), .LOOP(1'b0),
      .LED(LED1), .BUSY(BUSY1), .DONE(DONE1), .USBPU(USBPU1)
   );

   // 10 ns clock
   initial begin
      TEST_CLK = 1'b0;
      forever #5 TEST_CLK = ~TEST_CLK;
   end

   // Expected cycles for a run: every bit held div cycles for each pass, then DONE, then idle.
   task automatic push_pass(input logic [7:0] pat, input int div, input int passes);
      for (int p = 0; p < passes; p++)
         for (int i = 7; i >= 0; i--)
            for (int k = 0; k < div; k++)
               sb_q.push_back({pat[i], 1'b1, 1'b0});
      sb_q.push_back(3'b001);
      sb_q.push_back(3'b000);
   endtask

   // Issue a one-cycle LOAD to the TICK_DIV=4 instance (released by the caller's loop).
   task automatic start_load(input logic [7:0] pat, input logic loop_en);
      @(negedge TEST_CLK);
      PATTERN = pat;
      LOOP    = loop_en;
      LOAD    = 1'b1;
   endtask

   task automatic test_reset;
      RST_N = 1'b1;
      #1 RST_N = 1'b0;
      #2;
      n_compared++;
      if ({LED, BUSY, DONE, USBPU} !== 4'b0000) begin
         n_failed++;
         $display("[TB] FAIL reset_main: got led/busy/done/usbpu=%b, want 0000", {LED, BUSY, DONE, USBPU});
      end
      n_compared++;
      if ({LED1, BUSY1, DONE1, USBPU1} !== 4'b0000) begin
         n_failed++;
         $display("[TB] FAIL reset_tick1: got led/busy/done/usbpu=%b, want 0000", {LED1, BUSY1, DONE1, USBPU1});
      end
      repeat (2) @(negedge TEST_CLK);
      RST_N = 1'b1;
      repeat (2) @(negedge TEST_CLK);
      n_compared++;
      if ({LED, BUSY, DONE} !== 3'b000) begin
         n_failed++;
         $display("[TB] FAIL idle_after_reset: got led/busy/done=%b, want 000", {LED, BUSY, DONE});
      end
   endtask

   task automatic test_single_pass;
      int idx;
      sb_q.delete();
      start_load(8'b1011_0001, 1'b0);
      push_pass(8'b1011_0001, 4, 1);
      idx = 0;
      while (sb_q.size() > 0) begin
         @(negedge TEST_CLK);
         LOAD  = 1'b0;
         exp_v = sb_q.pop_front();
         obs_v = {LED, BUSY, DONE};
         n_compared++;
         if (obs_v !== exp_v || USBPU !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL single_pass[%0d]: got led/busy/done=%b usbpu=%b, want %b usbpu=0", idx, obs_v, USBPU, exp_v);
         end
         idx++;
      end
   endtask

   task automatic test_loop;
      int idx;
      sb_q.delete();
      start_load(8'h80, 1'b1);
      push_pass(8'h80, 4, 2);
      idx = 0;
      while (sb_q.size() > 0) begin
         @(negedge TEST_CLK);
         LOAD  = 1'b0;
         exp_v = sb_q.pop_front();
         obs_v = {LED, BUSY, DONE};
         n_compared++;
         if (obs_v !== exp_v || USBPU !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL loop[%0d]: got led/busy/done=%b usbpu=%b, want %b usbpu=0", idx, obs_v, USBPU, exp_v);
         end
         if (idx == 40) LOOP = 1'b0;
         idx++;
      end
   endtask

   task automatic test_ignore_load;
      int idx;
      sb_q.delete();
      start_load(8'b0110_1001, 1'b0);
      push_pass(8'b0110_1001, 4, 1);
      idx = 0;
      while (sb_q.size() > 0) begin
         @(negedge TEST_CLK);
         exp_v = sb_q.pop_front();
         obs_v = {LED, BUSY, DONE};
         n_compared++;
         if (obs_v !== exp_v || USBPU !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL ignore_load[%0d]: got led/busy/done=%b usbpu=%b, want %b usbpu=0", idx, obs_v, USBPU, exp_v);
         end
         LOAD = (idx == 10 || idx == 31);
         if (idx == 10) PATTERN = 8'hFF;
         idx++;
      end
   endtask

   task automatic test_async_reset;
      int idx;
      sb_q.delete();
      start_load(8'hF0, 1'b0);
      push_pass(8'hF0, 4, 1);
      for (idx = 0; idx <= 10; idx++) begin
         @(negedge TEST_CLK);
         LOAD  = 1'b0;
         exp_v = sb_q.pop_front();
         obs_v = {LED, BUSY, DONE};
         n_compared++;
         if (obs_v !== exp_v) begin
            n_failed++;
            $display("[TB] FAIL pre_reset[%0d]: got led/busy/done=%b, want %b", idx, obs_v, exp_v);
         end
      end
      #2 RST_N = 1'b0;
      #1;
      n_compared++;
      if ({LED, BUSY, DONE, USBPU} !== 4'b0000) begin
         n_failed++;
         $display("[TB] FAIL async_reset: got led/busy/done/usbpu=%b, want 0000", {LED, BUSY, DONE, USBPU});
      end
      repeat (2) @(negedge TEST_CLK);
      RST_N = 1'b1;
      @(negedge TEST_CLK);
      n_compared++;
      if ({LED, BUSY, DONE} !== 3'b000) begin
         n_failed++;
         $display("[TB] FAIL post_reset_no_done: got led/busy/done=%b, want 000", {LED, BUSY, DONE});
      end
      sb_q.delete();
      start_load(8'b1100_0011, 1'b0);
      push_pass(8'b1100_0011, 4, 1);
      idx = 0;
      while (sb_q.size() > 0) begin
         @(negedge TEST_CLK);
         LOAD  = 1'b0;
         exp_v = sb_q.pop_front();
         obs_v = {LED, BUSY, DONE};
         n_compared++;
         if (obs_v !== exp_v) begin
            n_failed++;
            $display("[TB] FAIL reload_after_reset[%0d]: got led/busy/done=%b, want %b", idx, obs_v, exp_v);
         end
         idx++;
      end
   endtask

   task automatic test_tick_div1;
      int idx;
      sb_q.delete();
      @(negedge TEST_CLK);
      PATTERN = 8'hA5;
      LOAD1   = 1'b1;
      push_pass(8'hA5, 1, 1);
      idx = 0;
      while (sb_q.size() > 0) begin
         @(negedge TEST_CLK);
         LOAD1 = 1'b0;
         exp_v = sb_q.pop_front();
         obs_v = {LED1, BUSY1, DONE1};
         n_compared++;
         if (obs_v !== exp_v || USBPU1 !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL tick_div1[%0d]: got led/busy/done=%b usbpu=%b, want %b usbpu=0", idx, obs_v, USBPU1, exp_v);
         end
         idx++;
      end
   endtask

   task automatic test_all_zero;
      int idx;
      sb_q.delete();
      start_load(8'h00, 1'b0);
      push_pass(8'h00, 4, 1);
      idx = 0;
      while (sb_q.size() > 0) begin
         @(negedge TEST_CLK);
         LOAD  = 1'b0;
         exp_v = sb_q.pop_front();
         obs_v = {LED, BUSY, DONE};
         n_compared++;
         if (obs_v !== exp_v || USBPU !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL all_zero[%0d]: got led/busy/done=%b usbpu=%b, want %b usbpu=0", idx, obs_v, USBPU, exp_v);
         end
         idx++;
      end
   endtask

   initial begin
      n_compared = 0;
      n_failed   = 0;
      PATTERN    = 8'h00;
      LOAD       = 1'b0;
      LOAD1      = 1'b0;
      LOOP       = 1'b0;
      test_reset();
      test_single_pass();
      test_loop();
      test_ignore_load();
      test_async_reset();
      test_tick_div1();
      test_all_zero();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
